// File: rtl/eth_pkg.sv
// Shared RMII Ethernet definitions: transmit FSM states, framing constants and CRC-32 parameters.
package eth_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PREAMBLE,
      DATA,
      PAD,
      FCS,
      IFG
   } tx_state_t;

   localparam int unsigned BYTE_W          = 8;
   localparam int unsigned DIBIT_W         = 2;
   localparam int unsigned CRC_W           = 32;
   localparam int unsigned BODY_CNT_W      = 6;
   localparam int unsigned PREAMBLE_DIBITS = 32;
   localparam int unsigned FCS_DIBITS      = 16;

   localparam logic [CRC_W-1:0]   CRC32_POLY = 32'hEDB88320;
   localparam logic [CRC_W-1:0]   CRC32_INIT = 32'hFFFFFFFF;
   localparam logic [DIBIT_W-1:0] SFD_DIBIT  = 2'b11;
   localparam logic [DIBIT_W-1:0] PRE_DIBIT  = 2'b01;

   // Body byte in flight; data doubles as the dibit shift register.
   typedef struct packed {
      logic              last;
      logic [BYTE_W-1:0] data;
   } tx_byte_t;

endpackage

// File: rtl/crc32_dibit.sv
// Combinational reflected CRC-32 step over one dibit, bit 0 first; shared with the RMII receive path.
module crc32_dibit
   import eth_pkg::*;
(
   input  logic [CRC_W-1:0]   crc_in,
   input  logic [DIBIT_W-1:0] dibit,
   output logic [CRC_W-1:0]   crc_out_c
);

   always_comb begin
      crc_out_c = crc_in;
      for (int i = 0; i < int'(DIBIT_W); i++) begin
         if (crc_out_c[0] ^ dibit[i]) begin
            crc_out_c = (crc_out_c >> 1) ^ CRC32_POLY;
         end else begin
            crc_out_c = crc_out_c >> 1;
         end
      end
   end

endmodule

// File: rtl/rmii_eth_tx.sv
// RMII transmitter: preamble/SFD, body with zero padding, CRC-32 FCS and inter-frame gap, two bits per clock.
module rmii_eth_tx
   import eth_pkg::*;
#(
   parameter int unsigned MIN_BODY   = 60,
   parameter int unsigned IFG_CYCLES = 48
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic [BYTE_W-1:0]  in_data,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   output logic               eth_txen,
   output logic [DIBIT_W-1:0] eth_txd,
   output logic               busy,
   output logic               underrun
);

   localparam int unsigned CNT_W = 5;
   localparam int unsigned IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

   localparam logic [CNT_W-1:0]      PRE_LAST = CNT_W'(PREAMBLE_DIBITS - 1);
   localparam logic [CNT_W-1:0]      SFD_POS  = CNT_W'(PREAMBLE_DIBITS - 2);
   localparam logic [CNT_W-1:0]      FCS_LAST = CNT_W'(FCS_DIBITS - 1);
   localparam logic [IFG_W-1:0]      IFG_LAST = IFG_W'(IFG_CYCLES - 1);
   localparam logic [BODY_CNT_W-1:0] BODY_MIN = BODY_CNT_W'(MIN_BODY);

   tx_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IFG_W-1:0]      ifg_q, ifg_d;
   tx_byte_t              cur_q, cur_d;
   logic [BODY_CNT_W-1:0] body_q, body_d, body_inc;
   logic [CRC_W-1:0]      crc_q, crc_d, crc_next;
   logic [DIBIT_W-1:0]    crc_dibit;

   logic                  txen_d, rdy_d, busy_d, under_d;
   logic [DIBIT_W-1:0]    txd_d;
   logic                  go_pre, go_byte, go_pad, go_fcs, go_ifg, go_under;

   // The state and counters describe the dibit currently on the wire.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ifg_q    <= '0;
         cur_q    <= '0;
         body_q   <= '0;
         crc_q    <= CRC32_INIT;
         eth_txen <= 1'b0;
         eth_txd  <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         underrun <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ifg_q    <= ifg_d;
         cur_q    <= cur_d;
         body_q   <= body_d;
         crc_q    <= crc_d;
         eth_txen <= txen_d;
         eth_txd  <= txd_d;
         in_ready <= rdy_d;
         busy     <= busy_d;
         underrun <= under_d;
      end
   end

   // Next body/pad dibit: a freshly accepted byte, the rest of the current byte, or pad zeros.
   always_comb begin
      crc_dibit = '0;
      if (in_ready && in_valid) begin
         crc_dibit = in_data[1:0];
      end else if (state_q == DATA && cnt_q[1:0] != 2'd3) begin
         crc_dibit = cur_q.data[3:2];
      end
   end

   assign body_inc = (body_q >= BODY_MIN) ? BODY_MIN : body_q + BODY_CNT_W'(1);

   crc32_dibit u_crc (
      .crc_in    (crc_q),
      .dibit     (crc_dibit),
      .crc_out_c (crc_next)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ifg_d    = ifg_q;
      cur_d    = cur_q;
      body_d   = body_q;
      crc_d    = crc_q;
      txen_d   = 1'b0;
      txd_d    = '0;
      rdy_d    = 1'b0;
      busy_d   = 1'b1;
      under_d  = 1'b0;
      go_pre   = 1'b0;
      go_byte  = 1'b0;
      go_pad   = 1'b0;
      go_fcs   = 1'b0;
      go_ifg   = 1'b0;
      go_under = 1'b0;

      unique case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            go_pre = in_valid;
         end
         PREAMBLE: begin
            if (cnt_q == PRE_LAST) begin
               go_byte  = in_valid;
               go_under = !in_valid;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               txen_d = 1'b1;
               txd_d  = (cnt_q == SFD_POS) ? SFD_DIBIT : PRE_DIBIT;
               rdy_d  = (cnt_q == SFD_POS);
            end
         end
         DATA: begin
            if (cnt_q[1:0] != 2'd3) begin
               cnt_d      = cnt_q + CNT_W'(1);
               txen_d     = 1'b1;
               txd_d      = crc_dibit;
               crc_d      = crc_next;
               cur_d.data = cur_q.data >> 2;
               rdy_d      = (cnt_q[1:0] == 2'd2) && !cur_q.last;
            end else if (!cur_q.last) begin
               go_byte  = in_valid;
               go_under = !in_valid;
            end else begin
               go_pad = (body_q < BODY_MIN);
               go_fcs = (body_q >= BODY_MIN);
            end
         end
         PAD: begin
            if (cnt_q[1:0] != 2'd3) begin
               cnt_d  = cnt_q + CNT_W'(1);
               txen_d = 1'b1;
               txd_d  = crc_dibit;
               crc_d  = crc_next;
            end else begin
               go_pad = (body_q < BODY_MIN);
               go_fcs = (body_q >= BODY_MIN);
            end
         end
         FCS: begin
            if (cnt_q == FCS_LAST) begin
               go_ifg = 1'b1;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               txen_d = 1'b1;
               txd_d  = ~crc_q[1:0];
               crc_d  = {2'b00, crc_q[CRC_W-1:2]};
            end
         end
         IFG: begin
            if (ifg_q == IFG_LAST) begin
               // A waiting frame starts straight out of the gap, keeping busy high.
               if (in_valid) begin
                  go_pre = 1'b1;
               end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            end else begin
               ifg_d = ifg_q + IFG_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (go_pre) begin
         state_d = PREAMBLE;
         cnt_d   = '0;
         txen_d  = 1'b1;
         txd_d   = PRE_DIBIT;
         crc_d   = CRC32_INIT;
         body_d  = '0;
         busy_d  = 1'b1;
      end
      if (go_byte) begin
         state_d    = DATA;
         cnt_d      = '0;
         cur_d.data = in_data;
         cur_d.last = in_last;
         body_d     = body_inc;
         txen_d     = 1'b1;
         txd_d      = crc_dibit;
         crc_d      = crc_next;
      end
      if (go_pad) begin
         state_d = PAD;
         cnt_d   = '0;
         cur_d   = '0;
         body_d  = body_inc;
         txen_d  = 1'b1;
         txd_d   = crc_dibit;
         crc_d   = crc_next;
      end
      if (go_fcs) begin
         state_d = FCS;
         cnt_d   = '0;
         txen_d  = 1'b1;
         txd_d   = ~crc_q[1:0];
         crc_d   = {2'b00, crc_q[CRC_W-1:2]};
      end
      if (go_under) begin
         under_d = 1'b1;
      end
      if (go_ifg || go_under) begin
         state_d = IFG;
         ifg_d   = '0;
      end
   end

endmodule
